// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared ISA encodings and FSM state type for the
// multicycle datapath.
package multicycle_pkg;

    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_SLT  = 4'd4;
    localparam logic [3:0] F_MUL  = 4'd5;
    localparam logic [3:0] F_MFHI = 4'd6;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MUL,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one multiplier bit per
// cycle, busy for exactly DATA_W cycles after start.
module seq_multiplier
    import multicycle_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2*DATA_W-1:0] prod_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;

    assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == CNT_W'(1));
    // Exposes the value being committed this cycle, so the final product
    // is available on the same cycle done_o is high.
    assign prod_o = acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= CNT_W'(DATA_W);
        end else if (busy_o) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: FSM-sequenced core on one shared memory port.
// Define MULTICYCLE_MUL_EN to add the iterative multiplier and HI register.
module multicycle_datapath
    import multicycle_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pc,
    output logic              halted,
    output logic              retire,
    output logic              illegal
);

    localparam logic [DATA_W-1:0] PC_RST = DATA_W'(RESET_PC);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                halt_q;
    logic [DATA_W-1:0]   rf_q [8];

    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] rs, rt, rd, wb_addr;
    logic [3:0]            funct;
    logic [DATA_W-1:0]     imm_sx, rs_val, rt_val, alu_res, addr_c;
    logic                  legal, is_mul, rf_we, req_c, we_c;
    logic                  ret_c, ill_c;

    assign op      = ir_q[15:13];
    assign rs      = ir_q[12:10];
    assign rt      = ir_q[9:7];
    assign rd      = ir_q[6:4];
    assign funct   = ir_q[3:0];
    assign imm_sx  = {{(DATA_W-7){ir_q[6]}}, ir_q[6:0]};
    assign rs_val  = (rs == '0) ? '0 : rf_q[rs];
    assign rt_val  = (rt == '0) ? '0 : rf_q[rt];
    assign wb_addr = (op == OP_RTYPE) ? rd : rt;

`ifdef MULTICYCLE_MUL_EN
    logic [DATA_W-1:0]   hi_q;
    logic                mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    assign mul_start = (state_q == S_DECODE) && is_mul;

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .start_i(mul_start),
        .a_i    (rs_val),
        .b_i    (rt_val),
        .busy_o (mul_busy),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hi_q <= '0;
        end else if (state_q == S_MUL && mul_done) begin
            hi_q <= mul_prod[2*DATA_W-1:DATA_W];
        end
    end
`endif

    always_comb begin
        legal  = 1'b1;
        is_mul = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
`ifdef MULTICYCLE_MUL_EN
                    F_MUL:  is_mul = 1'b1;
                    F_MFHI: legal  = 1'b1;
`endif
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // pc_q is already post-increment when EXEC runs, so BEQ target is pc+off.
    always_comb begin
        alu_res = a_q + imm_sx;
        if (op == OP_BEQ) begin
            alu_res = pc_q + {imm_sx[DATA_W-2:0], 1'b0};
        end else if (op == OP_RTYPE) begin
            unique case (funct)
                F_ADD:  alu_res = a_q + b_q;
                F_SUB:  alu_res = a_q - b_q;
                F_AND:  alu_res = a_q & b_q;
                F_OR:   alu_res = a_q | b_q;
                F_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                   ($signed(a_q) < $signed(b_q))};
`ifdef MULTICYCLE_MUL_EN
                F_MFHI: alu_res = hi_q;
`endif
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        rf_we   = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = pc_q;
        ret_c   = 1'b0;
        ill_c   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[INSTR_W-1:0];
                    pc_d    = pc_q + DATA_W'(2);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rs_val;
                b_d = rt_val;
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (!legal) begin
                    ill_c   = 1'b1;
                    state_d = S_FETCH;
                end else if (is_mul) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (op == OP_BEQ) begin
                    ret_c   = 1'b1;
                    state_d = S_FETCH;
                    if (a_q == b_q) pc_d = alu_res;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MUL: begin
`ifdef MULTICYCLE_MUL_EN
                if (mul_done || !mul_busy) begin
                    alu_d   = mul_prod[DATA_W-1:0];
                    state_d = S_WB;
                end
`else
                state_d = S_FETCH;
`endif
            end
            S_MEM: begin
                req_c  = 1'b1;
                we_c   = (op == OP_SW);
                addr_c = alu_q;
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        alu_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                ret_c = !halt_q;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            halt_q  <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            halt_q  <= (state_q == S_HALT);
            if (rf_we && wb_addr != '0) rf_q[wb_addr] <= alu_q;
        end
    end

    // Bus outputs are masked while Reset is held so a pending transfer drops.
    assign mem_req   = req_c && !Reset;
    assign mem_we    = we_c && !Reset;
    assign mem_addr  = addr_c;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign retire    = ret_c && !Reset;
    assign illegal   = ill_c && !Reset;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed programs against a word memory model,
// checking registers, stores, pc, pulses and cycle timing.
module tb_multicycle_datapath;
    import multicycle_pkg::*;

    localparam int W = 16;
    localparam logic [15:0] HALT_I = 16'hE000;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         mem_ready = 1'b1;
    logic         mem_req, mem_we, halted, retire, illegal;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [15:0] prog [128];
    logic [15:0] mem  [128];
    logic [15:0] st_addr [8];
    logic [15:0] st_data [8];
    logic [15:0] stall_exp = '0;
    int          ret_cyc [16];
    int          cyc, ret_n, ill_n, st_n, halt_req, stall_n, stall_bad;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        found;

    multicycle_datapath #(.DATA_W(W), .RESET_PC(0)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .halted   (halted),
        .retire   (retire),
        .illegal  (illegal)
    );

    always #5 Clock = ~Clock;

    assign mem_rdata = mem[mem_addr[7:1]];

    always @(posedge Clock) begin
        if (Reset) begin
            mem       <= prog;
            cyc       <= 0;
            ret_n     <= 0;
            ill_n     <= 0;
            st_n      <= 0;
            halt_req  <= 0;
            stall_n   <= 0;
            stall_bad <= 0;
        end else begin
            cyc <= cyc + 1;
            if (retire) begin
                if (ret_n < 16) ret_cyc[ret_n] <= cyc + 1;
                ret_n <= ret_n + 1;
            end
            if (illegal) ill_n <= ill_n + 1;
            if (halted && mem_req) halt_req <= halt_req + 1;
            if (mem_req && !mem_ready) begin
                stall_n <= stall_n + 1;
                if (mem_addr != stall_exp || mem_we) stall_bad <= stall_bad + 1;
            end
            if (mem_req && mem_ready && mem_we) begin
                mem[mem_addr[7:1]] <= mem_wdata;
                if (st_n < 8) begin
                    st_addr[st_n] <= mem_addr;
                    st_data[st_n] <= mem_wdata;
                end
                st_n <= st_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ri(input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [2:0] rd, input logic [3:0] f);
        return {OP_RTYPE, rs, rt, rd, f};
    endfunction

    function automatic logic [15:0] ii(input logic [2:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clr_prog();
        foreach (prog[i]) prog[i] = '0;
    endtask

    task automatic start_run();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_req", mem_req, 0);
        chk("rst_halted", halted, 0);
        Reset = 1'b0;
    endtask

    task automatic wait_ret(input int k, input string tag);
        int n = 0;
        while (ret_n < k && n < 300) begin
            @(negedge Clock);
            n++;
        end
        chk(tag, ret_n >= k, 1);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 500) begin
            @(negedge Clock);
            n++;
        end
        chk(tag, halted, 1);
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ADDI then ADD, zero-wait memory
        clr_prog();
        prog[0] = ii(OP_ADDI, 0, 1, 7'd5);
        prog[1] = ri(1, 1, 2, F_ADD);
        prog[2] = HALT_I;
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_pc", pc, 0);
        chk("rst_retire", retire, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_we", mem_we, 0);
        start_run();
        #1 chk("fetch_req_after_rst", mem_req, 1);
        wait_ret(2, "t1_ret2");
        chk("t1_ret0_cyc", ret_cyc[0], 4);
        chk("t1_ret1_cyc", ret_cyc[1], 8);
        chk("t1_pc", pc, 16'h0004);
        chk("t1_r1", dut.rf_q[1], 16'd5);
        chk("t1_r2", dut.rf_q[2], 16'd10);
        wait_halt("t1_halt");
        chk("t1_halt_ret_cyc", ret_cyc[2], 11);
        chk("t1_ret_total", ret_n, 3);
        chk("t1_halt_pc", pc, 16'h0006);

        // three wait cycles on the first fetch
        stall_exp = 16'h0000;
        mem_ready = 1'b0;
        start_run();
        repeat (3) @(negedge Clock);
        mem_ready = 1'b1;
        wait_ret(2, "t2_ret2");
        chk("t2_stall_cycles", stall_n, 3);
        chk("t2_stall_stable", stall_bad, 0);
        chk("t2_ret0_cyc", ret_cyc[0], 7);
        chk("t2_ret1_cyc", ret_cyc[1], 11);
        chk("t2_r2", dut.rf_q[2], 16'd10);

        // BEQ taken (7==7) then not taken (8!=7)
        clr_prog();
        prog[0] = ii(OP_ADDI, 0, 1, 7'd6);
        prog[1] = ii(OP_ADDI, 0, 2, 7'd7);
        prog[7] = ii(OP_ADDI, 1, 1, 7'd1);
        prog[8] = ii(OP_BEQ, 1, 2, 7'h7E);
        prog[9] = HALT_I;
        start_run();
        wait_ret(9, "t3_ret9");
        chk("t3_beq_taken_pc", pc, 16'h000E);
        chk("t3_beq_latency", ret_cyc[8] - ret_cyc[7], 3);
        wait_ret(11, "t3_ret11");
        chk("t3_beq_not_taken_pc", pc, 16'h0012);
        wait_halt("t3_halt");
        chk("t3_r1", dut.rf_q[1], 16'd8);
        chk("t3_ret_total", ret_n, 12);

        // SW / LW round trip and r0 write discard
        clr_prog();
        prog[0]  = ii(OP_LW, 0, 1, 7'h3E);
        prog[1]  = ii(OP_SW, 0, 1, 7'd6);
        prog[2]  = ii(OP_BEQ, 0, 0, 7'd2);
        prog[5]  = ii(OP_LW, 0, 3, 7'd6);
        prog[6]  = ii(OP_ADDI, 0, 0, 7'd5);
        prog[7]  = ii(OP_SW, 0, 0, 7'd8);
        prog[8]  = ii(OP_SW, 0, 3, 7'h20);
        prog[9]  = HALT_I;
        prog[31] = 16'h1234;
        start_run();
        wait_halt("t4_halt");
        chk("t4_lw_latency", ret_cyc[0], 5);
        chk("t4_sw_latency", ret_cyc[1] - ret_cyc[0], 4);
        chk("t4_store_count", st_n, 3);
        chk("t4_st0_addr", st_addr[0], 16'h0006);
        chk("t4_st0_data", st_data[0], 16'h1234);
        chk("t4_st1_r0_data", st_data[1], 16'h0000);
        chk("t4_st2_data", st_data[2], 16'h1234);
        chk("t4_r3", dut.rf_q[3], 16'h1234);
        chk("t4_r0", dut.rf_q[0], 16'h0000);

        // MUL 0xFFFF*0xFFFF and MFHI
        clr_prog();
        prog[0] = ii(OP_ADDI, 0, 1, 7'h7F);
        prog[1] = ii(OP_ADDI, 0, 5, 7'd3);
        prog[2] = ri(1, 1, 5, F_MUL);
        prog[3] = ri(0, 0, 6, F_MFHI);
        prog[4] = HALT_I;
        start_run();
        wait_halt("t5_halt");
        chk("t5_r1", dut.rf_q[1], 16'hFFFF);
`ifdef MULTICYCLE_MUL_EN
        chk("t5_mul_lo", dut.rf_q[5], 16'h0001);
        chk("t5_hi", dut.hi_q, 16'hFFFE);
        chk("t5_mfhi", dut.rf_q[6], 16'hFFFE);
        chk("t5_mul_latency", ret_cyc[2] - ret_cyc[1], 19);
        chk("t5_illegal", ill_n, 0);
        chk("t5_ret_total", ret_n, 5);
`else
        chk("t5_rd_unchanged", dut.rf_q[5], 16'd3);
        chk("t5_mfhi_nop", dut.rf_q[6], 16'd0);
        chk("t5_illegal", ill_n, 2);
        chk("t5_ret_total", ret_n, 3);
`endif

        // Reset while a load is stalled in MEM
        clr_prog();
        prog[0]  = ii(OP_LW, 0, 1, 7'h3E);
        prog[31] = 16'h1234;
        stall_exp = 16'h003E;
        start_run();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clock);
            if (mem_req && mem_addr == 16'h003E) found = 1'b1;
        end
        mem_ready = 1'b0;
        chk("t6_mem_reached", found, 1);
        repeat (2) @(negedge Clock);
        chk("t6_req_held", mem_req, 1);
        chk("t6_addr_held", mem_addr, 16'h003E);
        Reset = 1'b1;
        @(negedge Clock);
        chk("t6_req_dropped", mem_req, 0);
        chk("t6_we_dropped", mem_we, 0);
        chk("t6_pc_reset", pc, 0);
        chk("t6_r1_clear", dut.rf_q[1], 0);
        Reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("t6_refetch_req", mem_req, 1);
        chk("t6_refetch_addr", mem_addr, 16'h0000);

        // Undefined opcode then HALT
        clr_prog();
        prog[0] = 16'hA000;
        prog[1] = HALT_I;
        start_run();
        wait_halt("t7_halt");
        chk("t7_illegal", ill_n, 1);
        chk("t7_ret_total", ret_n, 1);
        repeat (10) @(negedge Clock);
        chk("t7_no_req_halted", halt_req, 0);
        chk("t7_still_halted", halted, 1);
        chk("t7_pc", pc, 16'h0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
